mp_regfile: RTL

Parametrised multi-port general register file with write-through bypass and per-register pending-write scoreboard. Serves the pipelined CPU in place of the single-write register file. It provides:
- NUM_RD combinational read ports and two write ports: writeback plus a secondary late-result port.
- Busy tracking so decode can detect RAW hazards without a separate hazard table.

---
 rtl/mp_regfile_pkg.sv | 17 +
 rtl/mp_regfile_sb.sv | 112 +++++++++++
 rtl/mp_regfile.sv | 100 ++++++++++
 3 files changed

// File: rtl/mp_regfile_pkg.sv
// Shared constants and types for the multi-port register file and its scoreboard.
// Address-zero handling is centralised here so every file agrees on the hardwired register.
package mp_regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = '0;

    // True when an address names a real (writable) register.
    function automatic logic is_live_addr(input logic [DEF_ADDR_W-1:0] addr);
        return addr != ZERO_REG;
    endfunction

endpackage

// File: rtl/mp_regfile_sb.sv
// Pending-write scoreboard: one saturating-aware counter per register, issue refusal when a
// counter is full, and per-read-port busy flags that already account for this cycle's retires.
module mp_regfile_sb
    import mp_regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     ret0_vld,
    input  logic [ADDR_W-1:0]        ret0_addr,
    input  logic                     ret1_vld,
    input  logic [ADDR_W-1:0]        ret1_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     issue_stall,
    output logic                     err_underflow
);

    localparam int              DEPTH   = 2**ADDR_W;
    localparam int              SUM_W   = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt     [DEPTH];
    logic [CNT_W-1:0] cnt_nxt [DEPTH];
    logic             err_q;
    logic             uf_any;
    logic             issue_ok;

    // Number of retiring ports (0..2) aimed at one register this cycle.
    function automatic logic [1:0] dec_of(
        input logic [ADDR_W-1:0] a,
        input logic              v0,
        input logic [ADDR_W-1:0] a0,
        input logic              v1,
        input logic [ADDR_W-1:0] a1
    );
        logic [1:0] d;
        d = {1'b0, v0 && (a0 == a)} + {1'b0, v1 && (a1 == a)};
        return d;
    endfunction

    assign issue_ok = issue_en && (issue_addr != ADDR_W'(ZERO_REG));

    // A full counter refuses a new producer unless one retires in the same cycle.
    always_comb begin
        issue_stall = 1'b0;
        if (!reset && issue_ok && (cnt[issue_addr] == CNT_MAX) &&
            (dec_of(issue_addr, ret0_vld, ret0_addr, ret1_vld, ret1_addr) == 2'd0)) begin
            issue_stall = 1'b1;
        end
    end

    always_comb begin
        logic [SUM_W-1:0] sum;
        logic [1:0]       d;
        logic             inc;
        uf_any = 1'b0;
        sum    = '0;
        d      = '0;
        inc    = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            inc = issue_ok && !issue_stall && (issue_addr == ADDR_W'(r));
            sum = SUM_W'(cnt[r]) + SUM_W'(inc);
            d   = dec_of(ADDR_W'(r), ret0_vld, ret0_addr, ret1_vld, ret1_addr);
            if (SUM_W'(d) > sum) begin
                cnt_nxt[r] = '0;
                uf_any     = 1'b1;
            end else begin
                cnt_nxt[r] = CNT_W'(sum - SUM_W'(d));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                cnt[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            if (uf_any) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_underflow = err_q && !reset;

    // Busy reflects what is still outstanding once this cycle's retires are counted.
    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [1:0]        d;
        ra      = '0;
        d       = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = rd_addr[k*ADDR_W +: ADDR_W];
            d  = dec_of(ra, ret0_vld, ret0_addr, ret1_vld, ret1_addr);
            rd_busy[k] = !reset && (ra != ADDR_W'(ZERO_REG)) &&
                         (SUM_W'(cnt[ra]) > SUM_W'(d));
        end
    end

endmodule

// File: rtl/mp_regfile.sv
// Multi-port register file: NUM_RD combinational reads, two prioritised write ports with
// optional same-cycle bypass, and a pending-write scoreboard for decode hazard checks.
module mp_regfile
    import mp_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic                     wr0_retire,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic                     wr1_retire,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic                     issue_stall,
    output logic                     err_underflow
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr0_ok;
    logic              wr1_ok;
    logic              wr1_commit;
    logic              ret0_vld;
    logic              ret1_vld;

    assign wr0_ok     = wr0_en && (wr0_addr != ADDR_W'(ZERO_REG));
    assign wr1_ok     = wr1_en && (wr1_addr != ADDR_W'(ZERO_REG));
    // Port 0 wins an address collision; port 1's data is dropped but its retire still counts.
    assign wr1_commit = wr1_ok && !(wr0_ok && (wr0_addr == wr1_addr));
    assign ret0_vld   = wr0_ok && wr0_retire;
    assign ret1_vld   = wr1_ok && wr1_retire;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
        end else begin
            if (wr1_commit) begin
                mem[wr1_addr] <= wr1_data;
            end
            if (wr0_ok) begin
                mem[wr0_addr] <= wr0_data;
            end
        end
    end

    // Register 0 is hardwired; during reset only bypassed write data can appear.
    always_comb begin
        logic [ADDR_W-1:0] ra;
        ra      = '0;
        rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = rd_addr[k*ADDR_W +: ADDR_W];
            if (ra != ADDR_W'(ZERO_REG)) begin
                if ((BYPASS != 0) && wr0_ok && (wr0_addr == ra)) begin
                    rd_data[k*DATA_W +: DATA_W] = wr0_data;
                end else if ((BYPASS != 0) && wr1_ok && (wr1_addr == ra)) begin
                    rd_data[k*DATA_W +: DATA_W] = wr1_data;
                end else if (!reset) begin
                    rd_data[k*DATA_W +: DATA_W] = mem[ra];
                end
            end
        end
    end

    mp_regfile_sb #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .CNT_W  (CNT_W)
    ) u_sb (
        .clk           (clk),
        .reset         (reset),
        .rd_addr       (rd_addr),
        .issue_en      (issue_en),
        .issue_addr    (issue_addr),
        .ret0_vld      (ret0_vld),
        .ret0_addr     (wr0_addr),
        .ret1_vld      (ret1_vld),
        .ret1_addr     (wr1_addr),
        .rd_busy       (rd_busy),
        .issue_stall   (issue_stall),
        .err_underflow (err_underflow)
    );

endmodule
